// File: rtl/arbiter4_rr_sched.sv
// arbiter4_rr_sched: four input FIFOs shared onto one registered output
// channel by a round-robin scheduler with valid/ready backpressure.
// Optional weighted bursts are enabled by defining ARB_RR_WEIGHT_EN.
//
// Handshake: a word moves across an interface on a clock edge where valid
// and ready are both high. The sender keeps valid and data stable until that
// edge. Ready never depends on valid in the same cycle.
module arbiter4_rr_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [3:0]             i_valid,
    input  logic [3:0][DATA_W-1:0] i_data,
    output logic [3:0]             o_ready,
    output logic                   o_valid,
    output logic [DATA_W-1:0]      o_data,
    output logic [1:0]             o_src,
    input  logic                   i_ready
`ifdef ARB_RR_WEIGHT_EN
    ,
    input  logic [7:0]             i_weight
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [4][FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr [4];
    logic [AW-1:0]     rd_ptr [4];
    logic [AW:0]       count  [4];

    logic [3:0] full;
    logic [3:0] empty;
    logic [3:0] push;
    logic [3:0] pop;

    logic       stage_free;
    logic       found;
    logic       grant;
    logic [1:0] winner;
    logic [1:0] r_ptr;

`ifdef ARB_RR_WEIGHT_EN
    logic [2:0] burst_cnt;
    logic [2:0] burst_next;
    logic [2:0] weight_w;
    logic       drains;
`endif

    // A full FIFO stays closed even if it is popped this cycle.
    assign o_ready    = ~full;
    assign stage_free = !o_valid || i_ready;

    // Per-channel status and push/pop strobes.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            full[n]  = (count[n] == (AW+1)'(FIFO_DEPTH));
            empty[n] = (count[n] == '0);
            push[n]  = i_valid[n] && !full[n];
            pop[n]   = grant && (winner == 2'(n));
        end
    end

    // Winner search: first non-empty FIFO after the last-granted channel,
    // wrapping round to the last-granted channel itself.
    always_comb begin
        found  = 1'b0;
        winner = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            if (!found && !empty[r_ptr + 2'(k)]) begin
                found  = 1'b1;
                winner = r_ptr + 2'(k);
            end
        end
`ifdef ARB_RR_WEIGHT_EN
        // An unfinished burst keeps the current channel ahead of the rotation.
        if (burst_cnt != 3'd0 && !empty[r_ptr]) begin
            found  = 1'b1;
            winner = r_ptr;
        end
`endif
        grant = stage_free && found;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int n = 0; n < 4; n++) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
                count[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (push[n]) begin
                    wr_ptr[n] <= wr_ptr[n] + AW'(1);
                end
                if (pop[n]) begin
                    rd_ptr[n] <= rd_ptr[n] + AW'(1);
                end
                count[n] <= count[n] + (AW+1)'(push[n]) - (AW+1)'(pop[n]);
            end
        end
    end

    // FIFO storage; only ever read at an occupied slot, so no reset needed.
    always_ff @(posedge i_clk) begin
        for (int n = 0; n < 4; n++) begin
            if (push[n]) begin
                mem[n][wr_ptr[n]] <= i_data[n];
            end
        end
    end

    // Output stage and last-grant pointer; everything holds while stalled.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_src   <= 2'd0;
            r_ptr   <= 2'd3;
        end else if (stage_free) begin
            if (found) begin
                o_valid <= 1'b1;
                o_data  <= mem[winner][rd_ptr[winner]];
                o_src   <= winner;
                r_ptr   <= winner;
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef ARB_RR_WEIGHT_EN
    // Burst bookkeeping for the granted channel; weight sampled at the grant.
    always_comb begin
        weight_w   = {1'b0, i_weight[{winner, 1'b0} +: 2]} + 3'd1;
        burst_next = (burst_cnt != 3'd0 && winner == r_ptr) ? burst_cnt + 3'd1 : 3'd1;
        drains     = (count[winner] == (AW+1)'(1)) && !push[winner];
    end

    // A burst ends when it reaches the weight or the channel runs dry.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            burst_cnt <= 3'd0;
        end else if (grant) begin
            burst_cnt <= (burst_next == weight_w || drains) ? 3'd0 : burst_next;
        end
    end
`endif

endmodule

// File: tb/tb_arbiter4_rr_sched.sv
// Bench for arbiter4_rr_sched: directed scenarios plus a random phase, all
// compared each cycle against a queue-based model of the scheduler.
// Define ARB_RR_WEIGHT_EN for both files to cover weighted bursts.
module tb_arbiter4_rr_sched;

    localparam int DEPTH = 4;
    localparam int DW    = 16;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [3:0]         i_valid = '0;
    logic [3:0][DW-1:0] i_data = '0;
    logic [3:0]         o_ready;
    logic               o_valid;
    logic [DW-1:0]      o_data;
    logic [1:0]         o_src;
    logic               i_ready = 1'b0;
`ifdef ARB_RR_WEIGHT_EN
    logic [7:0]         i_weight = '0;
    logic [7:0]         drv_weight = '0;
`endif

    arbiter4_rr_sched #(.FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_src     (o_src),
        .i_ready   (i_ready)
`ifdef ARB_RR_WEIGHT_EN
        ,
        .i_weight  (i_weight)
`endif
    );

    // Clock.
    always #5 clk = ~clk;

    // Scoreboard: words accepted per channel but not yet granted.
    logic [DW-1:0] exp_q [4][$];
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_src;
    int            m_last;
    int            m_burst;
    int            xfer_log [$];

    logic [3:0]         drv_valid = '0;
    logic [3:0][DW-1:0] drv_data = '0;
    logic               drv_ready = 1'b0;
    logic [3:0]         acc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int n = 0; n < 4; n++) exp_q[n].delete();
        m_valid = 0;
        m_data  = '0;
        m_src   = 0;
        m_last  = 3;
        m_burst = 0;
    endfunction

    // One cycle: called at a negedge; checks outputs, drives inputs,
    // advances the model across the next posedge, returns at next negedge.
    task automatic step();
        logic [3:0] rdy_m;
        bit         free;
        bit         found;
        int         win;
        int         c;
        for (int n = 0; n < 4; n++) rdy_m[n] = (exp_q[n].size() < DEPTH);
        check("o_valid", {31'd0, o_valid}, {31'd0, m_valid});
        check("o_ready", {28'd0, o_ready}, {28'd0, rdy_m});
        check("o_data", {16'd0, o_data}, {16'd0, m_data});
        check("o_src", {30'd0, o_src}, m_src);
        if (m_valid && drv_ready) xfer_log.push_back(m_src);

        i_valid = drv_valid;
        i_data  = drv_data;
        i_ready = drv_ready;
`ifdef ARB_RR_WEIGHT_EN
        i_weight = drv_weight;
`endif
        for (int n = 0; n < 4; n++) acc[n] = drv_valid[n] && rdy_m[n];

        free  = !m_valid || drv_ready;
        found = 0;
        win   = 0;
        if (free) begin
`ifdef ARB_RR_WEIGHT_EN
            if (m_burst > 0 && exp_q[m_last].size() > 0) begin
                found = 1;
                win   = m_last;
            end
`endif
            for (int k = 1; k <= 4; k++) begin
                c = (m_last + k) % 4;
                if (!found && exp_q[c].size() > 0) begin
                    found = 1;
                    win   = c;
                end
            end
            if (found) begin
                m_data  = exp_q[win].pop_front();
                m_valid = 1;
                m_src   = win;
`ifdef ARB_RR_WEIGHT_EN
                m_burst = (m_burst > 0 && win == m_last) ? m_burst + 1 : 1;
`endif
                m_last  = win;
            end else begin
                m_valid = 0;
            end
        end
        for (int n = 0; n < 4; n++) if (acc[n]) exp_q[n].push_back(drv_data[n]);
`ifdef ARB_RR_WEIGHT_EN
        if (found && (m_burst == int'(drv_weight[2*win +: 2]) + 1 || exp_q[win].size() == 0))
            m_burst = 0;
`endif
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        drv_valid = '0;
        for (int i = 0; i < cycles; i++) step();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic apply_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_o_valid", {31'd0, o_valid}, 32'd0);
        check("rst_o_data", {16'd0, o_data}, 32'd0);
        check("rst_o_src", {30'd0, o_src}, 32'd0);
        model_clear();
        drv_valid = '0;
        drv_ready = 1'b0;
        i_valid   = '0;
        i_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int p;
        int guard;
        int exp3 [8];
        logic [DW-1:0] words [5];
        exp3 = '{0, 1, 2, 3, 0, 1, 2, 3};
        model_clear();
        @(negedge clk);
        apply_reset();

        // Test 1: idle after reset.
        check("t1_valid", {31'd0, o_valid}, 32'd0);
        check("t1_ready", {28'd0, o_ready}, 32'hf);
        check("t1_data", {16'd0, o_data}, 32'd0);
        idle(3);

        // Test 2: single word on channel 2.
        drv_ready   = 1'b1;
        drv_valid   = 4'b0100;
        drv_data[2] = 16'hA5A5;
        step();
        drv_valid = '0;
        step();
        check("t2_valid", {31'd0, o_valid}, 32'd1);
        check("t2_data", {16'd0, o_data}, 32'h0000A5A5);
        check("t2_src", {30'd0, o_src}, 32'd2);
        step();
        check("t2_valid_low", {31'd0, o_valid}, 32'd0);
        idle(3);

        // Test 3: two words on every channel at once.
        apply_reset();
        drv_ready = 1'b1;
        xfer_log.delete();
        for (int w = 0; w < 2; w++) begin
            drv_valid = 4'hf;
            for (int n = 0; n < 4; n++) drv_data[n] = DW'($urandom);
            step();
        end
        idle(12);
        check("t3_count", xfer_log.size(), 32'd8);
        for (int i = 0; i < 8 && i < xfer_log.size(); i++) check("t3_src", xfer_log[i], exp3[i]);

        // Test 4: backpressure fills channel 1.
        apply_reset();
        drv_ready = 1'b0;
        for (int i = 0; i < 5; i++) words[i] = DW'($urandom);
        p = 0;
        guard = 0;
        while (p < 5 && guard < 20) begin
            drv_valid   = 4'b0010;
            drv_data[1] = words[p];
            step();
            if (acc[1]) p++;
            guard++;
        end
        drv_valid = '0;
        check("t4_pushed", p, 32'd5);
        step();
        check("t4_ready1", {31'd0, o_ready[1]}, 32'd0);
        check("t4_hold", {16'd0, o_data}, {16'd0, words[0]});
        drv_ready = 1'b1;
        idle(10);

        // Test 5: reset while FIFOs are half full and output is stalled.
        drv_ready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            drv_valid = 4'hf;
            for (int n = 0; n < 4; n++) drv_data[n] = DW'($urandom);
            step();
        end
        drv_valid = '0;
        check("t5_pre_valid", {31'd0, o_valid}, 32'd1);
        apply_reset();
        drv_ready = 1'b1;
        idle(8);

`ifdef ARB_RR_WEIGHT_EN
        // Test 6: weighted bursts, ch0 weight 4, ch1 weight 1.
        begin
            int cnt0;
            int cnt1;
            int exp6 [11];
            exp6 = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1};
            apply_reset();
            drv_weight = 8'b00_00_00_11;
            drv_ready  = 1'b1;
            xfer_log.delete();
            cnt0 = 0;
            cnt1 = 0;
            for (int i = 0; i < 40; i++) begin
                drv_valid = {2'b00, cnt1 < 6, cnt0 < 6};
                drv_data[0] = DW'($urandom);
                drv_data[1] = DW'($urandom);
                step();
                if (acc[0]) cnt0++;
                if (acc[1]) cnt1++;
            end
            drv_valid = '0;
            check("t6_count", xfer_log.size(), 32'd12);
            for (int i = 0; i < 11 && i < xfer_log.size(); i++) check("t6_src", xfer_log[i], exp6[i]);
        end
`endif

        // Random phase.
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            for (int n = 0; n < 4; n++) begin
                drv_valid[n] = ($urandom_range(0, 1) == 1);
                drv_data[n]  = DW'($urandom);
            end
            drv_ready = ($urandom_range(0, 3) != 0);
`ifdef ARB_RR_WEIGHT_EN
            if (i % 37 == 0) drv_weight = 8'($urandom);
`endif
            if (i == 1000) begin
                apply_reset();
            end
            step();
        end
        drv_ready = 1'b1;
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
